// File: rtl/countgen_pulsegen.sv
// Frequency multiplier: regenerates M square pulses per measured input period.
// Optional macro COUNTGEN_PULSEGEN_DITHER_EN spreads the division remainder over the revolution.
module countgen_pulsegen #(
  parameter int PERIOD_W = 32,
  parameter int MULT_W   = 8,
  parameter int MIN_STEP = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] period,
  input  logic [MULT_W-1:0]   multiplier,
  input  logic                enable,
  output logic                out,
  output logic [MULT_W-1:0]   pulse_index,
  output logic                locked,
  output logic                busy
);

  localparam int CNT_W = (PERIOD_W > 1) ? $clog2(PERIOD_W) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [PERIOD_W-1:0] clamp_step(input logic [PERIOD_W-1:0] q);
    return (q < PERIOD_W'(MIN_STEP)) ? PERIOD_W'(MIN_STEP) : q;
  endfunction

  state_t              state, state_nx;
  logic [MULT_W-1:0]   m_eff, m_lat;
  logic [PERIOD_W-1:0] p_lat;
  logic [PERIOD_W-1:0] quo, quo_nx;
  logic [MULT_W-1:0]   rem, rem_nx;
  logic [MULT_W:0]     rem_sh, rem_diff;
  logic                sub_ok;
  logic [CNT_W-1:0]    bit_cnt;
  logic                div_done;
  logic [PERIOD_W-1:0] step_new, step_cur;
  logic                pending;
  logic [PERIOD_W-1:0] counter, cur_len, half;
  logic [MULT_W:0]     idx_inc;
  logic                en_q, active, pulse_end, load_step;
`ifdef COUNTGEN_PULSEGEN_DITHER_EN
  logic [MULT_W-1:0]   rem_new, rem_cur;
`endif

  assign m_eff = (multiplier == '0) ? MULT_W'(1) : multiplier;

  // Restoring divider datapath: one quotient bit per busy cycle
  always_comb begin
    rem_sh   = {rem, quo[PERIOD_W-1]};
    rem_diff = rem_sh - {1'b0, m_lat};
    sub_ok   = (rem_sh >= {1'b0, m_lat});
    rem_nx   = sub_ok ? rem_diff[MULT_W-1:0] : rem_sh[MULT_W-1:0];
    quo_nx   = {quo[PERIOD_W-2:0], sub_ok};
  end

  assign div_done = busy && (bit_cnt == CNT_W'(PERIOD_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      p_lat    <= '0;
      m_lat    <= '0;
      quo      <= '0;
      rem      <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      step_new <= '0;
`ifdef COUNTGEN_PULSEGEN_DITHER_EN
      rem_new  <= '0;
`endif
    end else if (busy) begin
      quo     <= quo_nx;
      rem     <= rem_nx;
      bit_cnt <= bit_cnt + CNT_W'(1);
      if (div_done) begin
        busy     <= 1'b0;
        step_new <= clamp_step(quo_nx);
`ifdef COUNTGEN_PULSEGEN_DITHER_EN
        // A clamped step already overshoots the period, so no remainder is spread
        rem_new  <= (quo_nx < PERIOD_W'(MIN_STEP)) ? '0 : rem_nx;
`endif
      end
    end else if ((period != '0) && ((period != p_lat) || (m_eff != m_lat))) begin
      p_lat   <= period;
      m_lat   <= m_eff;
      quo     <= period;
      rem     <= '0;
      bit_cnt <= '0;
      busy    <= 1'b1;
    end
  end

  // Pulse generator: length of the current pulse and boundary detection
  always_comb begin
`ifdef COUNTGEN_PULSEGEN_DITHER_EN
    cur_len = step_cur + PERIOD_W'(pulse_index < rem_cur);
`else
    cur_len = step_cur;
`endif
    half      = cur_len >> 1;
    active    = enable && en_q;
    pulse_end = (state == RUN) && active && (counter == cur_len - PERIOD_W'(1));
    load_step = pending && ((state == IDLE) || !active || pulse_end);
    idx_inc   = {1'b0, pulse_index} + (MULT_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= 1'b0;
      step_cur    <= '0;
      counter     <= '0;
      pulse_index <= '0;
      en_q        <= 1'b0;
`ifdef COUNTGEN_PULSEGEN_DITHER_EN
      rem_cur     <= '0;
`endif
    end else begin
      en_q <= enable;
      if (load_step) begin
        step_cur <= step_new;
        pending  <= 1'b0;
`ifdef COUNTGEN_PULSEGEN_DITHER_EN
        rem_cur  <= rem_new;
`endif
      end
      if ((state == IDLE) || !active) begin
        counter     <= '0;
        pulse_index <= '0;
      end else if (pulse_end) begin
        counter     <= '0;
        pulse_index <= (idx_inc >= {1'b0, m_eff}) ? '0 : idx_inc[MULT_W-1:0];
      end else begin
        counter <= counter + PERIOD_W'(1);
      end
      // A fresh result outranks the clear of an older one consumed this edge
      if (div_done) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    locked   = 1'b0;
    out      = 1'b0;
    case (state)
      IDLE: if (pending) state_nx = RUN;
      RUN: begin
        locked = 1'b1;
        out    = active && (counter < half);
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
